// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NUM_REQ producers, the write arbiter and the downstream fifo write port.
// Producers raise req_valid[i] with req_data slice i held stable; a word moves when
// req_valid[i] && req_ack[i] at a clock edge, and ack is never given without valid.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      fifo_full;
  logic                      fifo_write;
  logic [DATA_W-1:0]         fifo_data;

  // Environment side: producers plus the fifo status.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ack, fifo_write, fifo_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ack, fifo_write, fifo_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers.
// Optional burst locking (IDLE/LOCK FSM) is compiled in when ARB_BURST_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  fifo_wr_arbiter_if.slave bus,
  output logic [IDX_W-1:0] grant_id,
  output logic [CNT_W-1:0] wr_count,
  output logic [IDX_W-1:0] rr_ptr_o,
  output logic             state_o
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_nxt;
  logic             grant;
  logic [IDX_W:0]   rr_pick_r;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod NUM_REQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDX_W-1:0]   start);
    logic [IDX_W:0] r;
    int             idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[IDX_W'(idx)]) r = {1'b1, IDX_W'(idx)};
    end
    return r;
  endfunction

`ifdef ARB_BURST_EN
  localparam int BC_W = $clog2(MAX_BURST + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] holder_q, holder_d;
  logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic             holder_valid;

  assign holder_valid = bus.req_valid[holder_q];

  // Winner: a locked holder that still has data overrides the round-robin scan.
  always_comb begin
    rr_pick_r = rr_pick(bus.req_valid, rr_ptr_q);
    win_vld   = rr_pick_r[IDX_W];
    win_idx   = rr_pick_r[IDX_W-1:0];
    if (state_q == LOCK && holder_valid) begin
      win_vld = 1'b1;
      win_idx = holder_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      holder_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      holder_q    <= holder_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    holder_d    = holder_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant && MAX_BURST > 1) begin
          state_d     = LOCK;
          holder_d    = win_idx;
          burst_cnt_d = BC_W'(1);
        end
      end
      LOCK: begin
        if (grant && holder_valid) begin
          if (burst_cnt_q == BC_W'(MAX_BURST - 1)) state_d = IDLE;
          else burst_cnt_d = burst_cnt_q + BC_W'(1);
        end else if (!bus.fifo_full && !holder_valid) begin
          // Holder dropped out; whoever won the same-cycle scan starts a fresh lock.
          state_d = IDLE;
          if (grant && MAX_BURST > 1) begin
            state_d     = LOCK;
            holder_d    = win_idx;
            burst_cnt_d = BC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
`else
  always_comb begin
    rr_pick_r = rr_pick(bus.req_valid, rr_ptr_q);
    win_vld   = rr_pick_r[IDX_W];
    win_idx   = rr_pick_r[IDX_W-1:0];
  end

  assign state_o = IDLE;
`endif

  // Zero-latency grant: nothing leaves while the fifo is full or reset is held.
  assign grant   = win_vld && !bus.fifo_full && reset;
  assign win_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  always_comb begin
    bus.req_ack    = '0;
    bus.fifo_write = 1'b0;
    bus.fifo_data  = '0;
    if (grant) begin
      bus.req_ack[win_idx] = 1'b1;
      bus.fifo_write       = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_idx == IDX_W'(i)) bus.fifo_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    wr_count_d = wr_count_q;
    if (grant) begin
      rr_ptr_d   = win_nxt;
      grant_id_d = win_idx;
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign grant_id = grant_id_q;
  assign wr_count = wr_count_q;
  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; a negedge monitor pops expected {write, ack, data}
// entries from exp_q. Burst-mode expectations are selected with ARB_BURST_EN.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 2;
  localparam int W       = 1 + NUM_REQ + DATA_W;

  logic             clk;
  logic             reset;
  logic [IDX_W-1:0] grant_id;
  logic [CNT_W-1:0] wr_count;
  logic [IDX_W-1:0] rr_ptr_o;
  logic             state_o;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .grant_id(grant_id), .wr_count(wr_count), .rr_ptr_o(rr_ptr_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]       exp_q[$];
  int                 checks;
  int                 errors;
  int                 rem[NUM_REQ];
  int                 seq[NUM_REQ];
  logic [NUM_REQ-1:0] ack_seen;

  function automatic logic [DATA_W-1:0] mk_data(input int i, input int s);
    return DATA_W'((i << 4) | (s & 15));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input int s);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1 << i);
    exp_q.push_back({1'b1, oh, mk_data(i, s)});
  endtask

  // driver tasks
  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = (rem[i] > 0);
      bus.req_data[i*DATA_W +: DATA_W] = mk_data(i, seq[i]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ack_seen = bus.req_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_seen[i] && rem[i] > 0) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input int limit, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      got = {bus.fifo_write, bus.req_ack, bus.fifo_data};
      if (bus.fifo_write || (|bus.req_ack)) begin
        checks++;
        if (bus.fifo_full) begin
          errors++;
          $display("FAIL write_while_full got=%0h", got);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got=%0h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write_word got=%0h exp=%0h", got, e);
          end
        end
      end else begin
        checks++;
        if (bus.fifo_data !== '0) begin
          errors++;
          $display("FAIL idle_data got=%0h exp=0", bus.fifo_data);
        end
      end
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    ack_seen = '0;
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 1;
      seq[i] = 0;
    end
    drive();
    fork
      monitor();
    join_none

    // reset with all requesters valid
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_ack", 32'(bus.req_ack), 32'd0);
      check("rst_write", 32'(bus.fifo_write), 32'd0);
      check("rst_data", 32'(bus.fifo_data), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_rr_ptr", 32'(rr_ptr_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) push_exp(i, 0);
    drain(20, n);
    check("first_round_cycles", 32'(n), 32'd4);
    check("first_round_count", 32'(wr_count), 32'd4);
    check("first_round_gid", 32'(grant_id), 32'd3);
    check("first_round_ptr", 32'(rr_ptr_o), 32'd0);

`ifndef ARB_BURST_EN
    // fairness: 8 cycles, order 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 2;
    drive();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push_exp(i, r);
    drain(20, n);
    check("fair_cycles", 32'(n), 32'd8);
    check("fair_count", 32'(wr_count), 32'd8);
    check("fair_state", 32'(state_o), 32'd0);
`endif

    // only req 2 valid, fifo_full toggles 1,0,1,0
    do_reset();
    rem[2] = 2;
    drive();
    push_exp(2, 0);
    push_exp(2, 1);
    for (int k = 0; k < 4; k++) begin
      bus.fifo_full = (k % 2 == 0);
      step();
      if (k == 0) check("full_stall_count", 32'(wr_count), 32'd0);
    end
    bus.fifo_full = 1'b0;
    check("full_none_dropped", 32'(exp_q.size()), 32'd0);
    check("full_count", 32'(wr_count), 32'd2);
    check("full_gid", 32'(grant_id), 32'd2);
    check("full_ptr", 32'(rr_ptr_o), 32'd3);

    // wrap path: rr_ptr=3, reqs 1 and 3 valid
    rem[1] = 1;
    rem[3] = 1;
    drive();
    push_exp(3, 0);
    push_exp(1, 0);
    step();
    check("wrap_gid_a", 32'(grant_id), 32'd3);
    check("wrap_ptr_a", 32'(rr_ptr_o), 32'd0);
    step();
    check("wrap_gid_b", 32'(grant_id), 32'd1);
    check("wrap_ptr_b", 32'(rr_ptr_o), 32'd2);
    check("wrap_empty", 32'(exp_q.size()), 32'd0);

    // statistics counter wrap with CNT_W=4
    do_reset();
    rem[0] = 17;
    drive();
    for (int s = 0; s < 17; s++) push_exp(0, s);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) check("cnt_15", 32'(wr_count), 32'd15);
      if (k == 16) check("cnt_16_wrap", 32'(wr_count), 32'd0);
      if (k == 17) check("cnt_17", 32'(wr_count), 32'd1);
    end
    check("cnt_empty", 32'(exp_q.size()), 32'd0);

`ifdef ARB_BURST_EN
    // bursts of 4; req 0 leaves after 2 words and req 1 takes the same cycle
    do_reset();
    rem[0] = 2;
    for (int i = 1; i < NUM_REQ; i++) rem[i] = 4;
    drive();
    push_exp(0, 0);
    push_exp(0, 1);
    for (int i = 1; i < NUM_REQ; i++)
      for (int s = 0; s < 4; s++) push_exp(i, s);
    step();
    check("burst_lock", 32'(state_o), 32'd1);
    drain(30, n);
    check("burst_cycles", 32'(n), 32'd13);
    check("burst_count", 32'(wr_count), 32'd14);
    check("burst_exit", 32'(state_o), 32'd0);
    check("burst_ptr", 32'(rr_ptr_o), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
